// File: rtl/param_queue_enq_arbiter.sv
// Round-robin arbiter sharing one ParamQueue enqueue port among N_REQ producers.
// A winner may hold the port for up to BURST consecutive writes before priority rotates.
module param_queue_enq_arbiter #(
    parameter int WIDTH = 8,
    parameter int N_REQ = 4,
    parameter int BURST = 2,
    parameter int CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] req_data,
    output logic [N_REQ-1:0]       gnt,
    input  logic                   q_full,
    output logic                   q_enqueue,
    output logic [WIDTH-1:0]       q_data_in,
    output logic                   stall,
    output logic [CNT_W-1:0]       grant_cnt
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BC_W  = $clog2(BURST + 1);

    logic [PTR_W-1:0] ptr;
    logic [BC_W-1:0]  cnt;
    logic [PTR_W-1:0] win;
    logic             found;
    logic             grant_ok;
    logic [BC_W-1:0]  cnt_next;
    int               idx;

    // Scan starting at ptr, wrapping modulo N_REQ; the first pending request wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = int'(ptr) + i;
            if (idx >= N_REQ) begin
                idx = idx - N_REQ;
            end
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = PTR_W'(idx);
            end
        end
    end

    always_comb begin
        grant_ok  = (|req) && !q_full && !rst;
        stall     = (|req) && q_full && !rst;
        gnt       = '0;
        q_enqueue = 1'b0;
        q_data_in = '0;
        if (grant_ok) begin
            gnt[win]  = 1'b1;
            q_enqueue = 1'b1;
            q_data_in = req_data[int'(win)*WIDTH +: WIDTH];
        end
    end

    assign cnt_next = (win == ptr) ? cnt + BC_W'(1) : BC_W'(1);

    // Without a grant everything holds, so a burst stalled by q_full resumes where it stopped.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr       <= '0;
            cnt       <= '0;
            grant_cnt <= '0;
        end else if (grant_ok) begin
            grant_cnt <= grant_cnt + CNT_W'(1);
            if (cnt_next == BC_W'(BURST)) begin
                ptr <= (win == PTR_W'(N_REQ - 1)) ? '0 : win + PTR_W'(1);
                cnt <= '0;
            end else begin
                ptr <= win;
                cnt <= cnt_next;
            end
        end
    end

endmodule

// File: tb/tb_param_queue_enq_arbiter.sv
// Scoreboard bench for param_queue_enq_arbiter: a reference model pushes expected outputs
// each cycle, popped and compared at the falling edge, plus directed grant sequences.
module tb_param_queue_enq_arbiter;

    localparam int WIDTH = 8;
    localparam int N_REQ = 4;
    localparam int BURST = 2;
    localparam int CNT_W = 16;

    logic                   clk;
    logic                   rst;
    logic [N_REQ-1:0]       req;
    logic [N_REQ*WIDTH-1:0] req_data;
    logic [N_REQ-1:0]       gnt;
    logic                   q_full;
    logic                   q_enqueue;
    logic [WIDTH-1:0]       q_data_in;
    logic                   stall;
    logic [CNT_W-1:0]       grant_cnt;

    typedef struct {
        logic [N_REQ-1:0] gnt;
        logic             enq;
        logic [WIDTH-1:0] data;
        logic             stall;
        logic [CNT_W-1:0] gcnt;
    } exp_t;

    exp_t sb[$];

    int vectors;
    int miscompares;
    int m_ptr;
    int m_cnt;
    int m_gcnt;

    param_queue_enq_arbiter #(
        .WIDTH(WIDTH),
        .N_REQ(N_REQ),
        .BURST(BURST),
        .CNT_W(CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .q_full   (q_full),
        .q_enqueue(q_enqueue),
        .q_data_in(q_data_in),
        .stall    (stall),
        .grant_cnt(grant_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        if (obs !== expv) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
        end
    endtask

    // Drive one cycle of stimulus just after a rising edge, predict, compare at the falling edge,
    // then advance the model across the next rising edge.
    task automatic applyStimulus(input logic [N_REQ-1:0] r, input logic f, input logic rs,
                                 input logic [N_REQ*WIDTH-1:0] d,
                                 input bit use_dir, input logic [N_REQ-1:0] dir_gnt);
        exp_t e;
        exp_t got;
        int   w;
        bit   grant;
        int   nc;
        req      = r;
        q_full   = f;
        rst      = rs;
        req_data = d;
        w = -1;
        for (int k = 0; k < N_REQ; k++) begin
            if (w < 0 && r[(m_ptr + k) % N_REQ]) w = (m_ptr + k) % N_REQ;
        end
        grant   = (r != 0) && !f && !rs;
        e.stall = (r != 0) && f && !rs;
        e.gnt   = grant ? N_REQ'(1 << w) : '0;
        e.enq   = grant;
        e.data  = grant ? d[w*WIDTH +: WIDTH] : '0;
        e.gcnt  = CNT_W'(m_gcnt);
        sb.push_back(e);

        @(negedge clk);
        got = sb.pop_front();
        checkOutput("gnt", 32'(gnt), 32'(got.gnt));
        checkOutput("q_enqueue", 32'(q_enqueue), 32'(got.enq));
        checkOutput("q_data_in", 32'(q_data_in), 32'(got.data));
        checkOutput("stall", 32'(stall), 32'(got.stall));
        checkOutput("grant_cnt", 32'(grant_cnt), 32'(got.gcnt));
        if (use_dir) checkOutput("dir_gnt", 32'(gnt), 32'(dir_gnt));

        @(posedge clk);
        if (rs) begin
            m_ptr = 0; m_cnt = 0; m_gcnt = 0;
        end else if (grant) begin
            nc = (w == m_ptr) ? m_cnt + 1 : 1;
            if (nc == BURST) begin
                m_ptr = (w + 1) % N_REQ;
                m_cnt = 0;
            end else begin
                m_ptr = w;
                m_cnt = nc;
            end
            m_gcnt = (m_gcnt + 1) % (1 << CNT_W);
        end
        #1;
    endtask

    logic [N_REQ*WIDTH-1:0] fixed_data;
    logic [N_REQ-1:0]       rot_tbl [9];

    initial begin
        vectors     = 0;
        miscompares = 0;
        m_ptr = 0; m_cnt = 0; m_gcnt = 0;
        fixed_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        rot_tbl = '{4'b0001, 4'b0001, 4'b0010, 4'b0010, 4'b0100, 4'b0100,
                    4'b1000, 4'b1000, 4'b0001};
        rst = 1'b1; req = '0; q_full = 1'b0; req_data = '0;
        @(posedge clk);
        #1;

        // Reset held two cycles with all requests pending, then rotation at full rate.
        repeat (2) applyStimulus(4'b1111, 1'b0, 1'b1, fixed_data, 1'b1, 4'b0000);
        for (int i = 0; i < 9; i++) applyStimulus(4'b1111, 1'b0, 1'b0, fixed_data, 1'b1, rot_tbl[i]);
        checkOutput("rot_count", 32'(grant_cnt), 32'd9);

        // Single requester keeps the port across burst boundaries.
        applyStimulus(4'b0000, 1'b0, 1'b1, fixed_data, 1'b0, 4'b0000);
        for (int i = 0; i < 6; i++) applyStimulus(4'b0100, 1'b0, 1'b0, fixed_data, 1'b1, 4'b0100);

        // Backpressure interrupts a burst, which then completes.
        applyStimulus(4'b1111, 1'b0, 1'b1, fixed_data, 1'b0, 4'b0000);
        applyStimulus(4'b1111, 1'b0, 1'b0, fixed_data, 1'b1, 4'b0001);
        for (int i = 0; i < 3; i++) applyStimulus(4'b1111, 1'b1, 1'b0, fixed_data, 1'b1, 4'b0000);
        checkOutput("bp_frozen", 32'(grant_cnt), 32'd1);
        applyStimulus(4'b1111, 1'b0, 1'b0, fixed_data, 1'b1, 4'b0001);
        applyStimulus(4'b1111, 1'b0, 1'b0, fixed_data, 1'b1, 4'b0010);

        // Owner drops mid-burst; the next requester starts a fresh count.
        applyStimulus(4'b0000, 1'b0, 1'b1, fixed_data, 1'b0, 4'b0000);
        applyStimulus(4'b0011, 1'b0, 1'b0, fixed_data, 1'b1, 4'b0001);
        applyStimulus(4'b0010, 1'b0, 1'b0, fixed_data, 1'b1, 4'b0010);
        applyStimulus(4'b0010, 1'b0, 1'b0, fixed_data, 1'b1, 4'b0010);
        applyStimulus(4'b0011, 1'b0, 1'b0, fixed_data, 1'b1, 4'b0001);

        // Reset in the middle of operation discards burst state and the counter.
        applyStimulus(4'b0000, 1'b0, 1'b1, fixed_data, 1'b0, 4'b0000);
        for (int i = 0; i < 5; i++) applyStimulus(4'b1111, 1'b0, 1'b0, fixed_data, 1'b0, 4'b0000);
        applyStimulus(4'b1111, 1'b0, 1'b1, fixed_data, 1'b1, 4'b0000);
        checkOutput("mid_rst_cnt", 32'(grant_cnt), 32'd0);
        applyStimulus(4'b1111, 1'b0, 1'b0, fixed_data, 1'b1, 4'b0001);

        // Random traffic with backpressure, changing data and occasional reset.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(N_REQ'($urandom_range(0, 15)),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 49) == 0),
                          {$urandom()}, 1'b0, 4'b0000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
